// File: rtl/mon_seq_pkg.sv
// Shared encodings for the AGC monitor-port sequencer: opcodes, response
// error codes, FSM states and the MDT bus width.
package mon_seq_pkg;

  localparam int MDT_W = 16;

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_STOP  = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_LDCH  = 3'd4;
  localparam logic [2:0] OP_RDCH  = 3'd5;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_GOJAM   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_STOP_WAIT = 3'd2,
    S_ARM       = 3'd3,
    S_ADDR      = 3'd4,
    S_DATA      = 3'd5,
    S_FINISH    = 3'd6,
    S_RESP      = 3'd7
  } state_t;

  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_RDCH;
  endfunction

  // Memory/channel transfers only make sense while the core is stopped.
  function automatic logic op_needs_stop(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_READ) || (op == OP_LDCH) || (op == OP_RDCH);
  endfunction

  function automatic logic op_is_read(input logic [2:0] op);
    return (op == OP_READ) || (op == OP_RDCH);
  endfunction

endpackage

// File: rtl/mon_edge_det.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the input rises.
module mon_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic q;
  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;

endmodule

// File: rtl/mon_sequencer.sv
// Monitor-port transaction sequencer: turns one command into a cycle-exact
// MSTRT/MSTP/MLOAD/MREAD/MLDCH/MRDCH/MDT sequence locked to MT01/MT07/MT10/MT12.
module mon_sequencer
  import mon_seq_pkg::*;
#(
  parameter int unsigned START_CYCLES   = 250,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid and its payload stay stable until that edge.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [15:0]      cmd_addr,
  input  logic [15:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [1:0]       rsp_err,
  input  logic             MT01,
  input  logic             MT07,
  input  logic             MT10,
  input  logic             MT12,
  input  logic             MGOJAM,
  input  logic [15:0]      MWL,
  output logic             MSTRT,
  output logic             MSTP,
  output logic             MREAD,
  output logic             MLOAD,
  output logic             MRDCH,
  output logic             MLDCH,
  output logic [MDT_W-1:0] MDT,
  output logic             stopped,
  output state_t           dbg_state
);

  state_t      state;
  logic [2:0]  op_q;
  logic [15:0] data_q;
  logic [31:0] start_cnt;
  logic [31:0] wdog;
  logic        mt01_rise, mt07_rise, mt10_rise, mt12_rise;
  logic        in_wait, gojam_hit, timeout_hit;

  mon_edge_det u_mt01 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .din(MT01), .rise(mt01_rise));
  mon_edge_det u_mt07 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .din(MT07), .rise(mt07_rise));
  mon_edge_det u_mt10 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .din(MT10), .rise(mt10_rise));
  mon_edge_det u_mt12 (.clk(SIM_CLK), .rst_n(SIM_RST_n), .din(MT12), .rise(mt12_rise));

  assign in_wait     = (state == S_STOP_WAIT) || (state == S_ARM) ||
                       (state == S_ADDR) || (state == S_DATA);
  assign gojam_hit   = MGOJAM && (in_wait || (state == S_START));
  assign timeout_hit = in_wait && (wdog == 32'(TIMEOUT_CYCLES - 1));
  assign dbg_state   = state;

  always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state     <= S_IDLE;
      op_q      <= OP_START;
      data_q    <= '0;
      start_cnt <= '0;
      wdog      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      MSTRT     <= 1'b0;
      MSTP      <= 1'b0;
      MREAD     <= 1'b0;
      MLOAD     <= 1'b0;
      MRDCH     <= 1'b0;
      MLDCH     <= 1'b0;
      MDT       <= '0;
      stopped   <= 1'b0;
    end else if (gojam_hit || timeout_hit) begin
      // Abort path: every strobe drops now, FINISH then reports the cause.
      MSTRT   <= 1'b0;
      MREAD   <= 1'b0;
      MLOAD   <= 1'b0;
      MRDCH   <= 1'b0;
      MLDCH   <= 1'b0;
      MDT     <= '0;
      rsp_err <= gojam_hit ? ERR_GOJAM : ERR_TIMEOUT;
      if (gojam_hit) stopped <= 1'b0;
      state   <= S_FINISH;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            cmd_ready <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= ERR_OK;
            start_cnt <= '0;
            wdog      <= '0;
            if (op_illegal(cmd_op) || (op_needs_stop(cmd_op) && !stopped)) begin
              rsp_err   <= ERR_ILLEGAL;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              case (cmd_op)
                OP_START: begin
                  MSTP    <= 1'b0;
                  stopped <= 1'b0;
                  MSTRT   <= 1'b1;
                  state   <= S_START;
                end
                OP_STOP: begin
                  MSTP  <= 1'b1;
                  state <= S_STOP_WAIT;
                end
                OP_LOAD: begin
                  MLOAD <= 1'b1;
                  MDT   <= cmd_addr;
                  state <= S_ARM;
                end
                OP_READ: begin
                  MREAD <= 1'b1;
                  MDT   <= cmd_addr;
                  state <= S_ARM;
                end
                OP_LDCH: begin
                  MLDCH <= 1'b1;
                  MDT   <= {7'b0, cmd_addr[8:0]};
                  state <= S_ARM;
                end
                default: begin
                  MRDCH <= 1'b1;
                  MDT   <= {7'b0, cmd_addr[8:0]};
                  state <= S_ARM;
                end
              endcase
            end
          end
        end
        S_START: begin
          if (start_cnt == 32'(START_CYCLES - 1)) begin
            MSTRT     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            start_cnt <= start_cnt + 32'd1;
          end
        end
        S_STOP_WAIT: begin
          if (mt12_rise) begin
            stopped   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        S_ARM: begin
          if (mt01_rise) begin
            wdog  <= '0;
            state <= S_ADDR;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        S_ADDR: begin
          if (mt07_rise) begin
            if (!op_is_read(op_q)) MDT <= data_q;
            wdog  <= '0;
            state <= S_DATA;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        S_DATA: begin
          // Capture happens even when MT12 arrives in the same cycle.
          if (mt10_rise && op_is_read(op_q)) rsp_data <= MWL;
          if (mt12_rise) begin
            MREAD <= 1'b0;
            MLOAD <= 1'b0;
            MRDCH <= 1'b0;
            MLDCH <= 1'b0;
            MDT   <= '0;
            state <= S_FINISH;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        S_FINISH: begin
          if (MGOJAM) begin
            rsp_err <= ERR_GOJAM;
            stopped <= 1'b0;
          end
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mon_sequencer.sv
// Directed bench for mon_sequencer: per-cycle expected monitor outputs plus a
// response queue, with literal checks on key results.
module tb_mon_sequencer;
  import mon_seq_pkg::*;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        MT01, MT07, MT10, MT12, MGOJAM;
  logic [15:0] MWL;
  logic        MSTRT, MSTP, MREAD, MLOAD, MRDCH, MLDCH;
  logic [15:0] MDT;
  logic        stopped;
  state_t      dbg_state;

  always #5 SIM_CLK = ~SIM_CLK;

  mon_sequencer #(.START_CYCLES(250), .TIMEOUT_CYCLES(100)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST_n(SIM_RST_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .MT01(MT01), .MT07(MT07), .MT10(MT10), .MT12(MT12), .MGOJAM(MGOJAM), .MWL(MWL),
    .MSTRT(MSTRT), .MSTP(MSTP), .MREAD(MREAD), .MLOAD(MLOAD), .MRDCH(MRDCH), .MLDCH(MLDCH),
    .MDT(MDT), .stopped(stopped), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int mstrt_cycles = 0;
  bit chk_en = 1'b0;

  // Expected output model, updated by the driver from the transaction timeline.
  logic        exp_mstrt, exp_mstp, exp_mread, exp_mload, exp_mrdch, exp_mldch;
  logic [15:0] exp_mdt;
  logic        exp_stopped, exp_cmd_ready, exp_rsp_valid;
  logic [17:0] exp_q[$];
  logic [15:0] last_data;
  logic [1:0]  last_err;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic exp_reset();
    exp_mstrt = 0; exp_mstp = 0; exp_mread = 0; exp_mload = 0; exp_mrdch = 0; exp_mldch = 0;
    exp_mdt = 16'h0; exp_stopped = 0; exp_cmd_ready = 1; exp_rsp_valid = 0;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] data);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_cmd_ready = 1'b0;
  endtask

  // m = {MT12, MT10, MT07, MT01}; one-cycle pulse, returns after the action edge.
  task automatic pulse(input logic [3:0] m);
    {MT12, MT10, MT07, MT01} = m;
    tick();
    {MT12, MT10, MT07, MT01} = 4'b0;
    tick();
  endtask

  task automatic take_rsp(input int hold);
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_cmd_ready = 1'b1;
    tick();
  endtask

  always @(negedge SIM_CLK) begin
    if (chk_en) begin
      cmp("MSTRT", MSTRT, exp_mstrt);
      cmp("MSTP", MSTP, exp_mstp);
      cmp("MREAD", MREAD, exp_mread);
      cmp("MLOAD", MLOAD, exp_mload);
      cmp("MRDCH", MRDCH, exp_mrdch);
      cmp("MLDCH", MLDCH, exp_mldch);
      cmp("MDT", MDT, exp_mdt);
      cmp("stopped", stopped, exp_stopped);
      cmp("cmd_ready", cmd_ready, exp_cmd_ready);
      cmp("rsp_valid", rsp_valid, exp_rsp_valid);
      if (exp_rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_queue: response expected but queue empty at %0t", $time);
        end else begin
          cmp("rsp_data", rsp_data, exp_q[0][15:0]);
          cmp("rsp_err", {14'b0, rsp_err}, {14'b0, exp_q[0][17:16]});
          if (rsp_ready) begin
            last_data = rsp_data;
            last_err  = rsp_err;
            void'(exp_q.pop_front());
          end
        end
      end
      if (MSTRT === 1'b1) mstrt_cycles++;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: bench did not complete at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 0;
    {MT12, MT10, MT07, MT01} = 4'b0; MGOJAM = 0; MWL = 16'h0;
    last_data = 16'h0; last_err = 2'd0;
    exp_reset();
    tick();
    chk_en = 1'b1;
    tick();
    cmp("rst_cmd_ready", cmd_ready, 16'h1);
    cmp("rst_rsp_data", rsp_data, 16'h0);
    SIM_RST_n = 1'b1;
    tick();

    // START: MSTRT high exactly 250 cycles, response the cycle after.
    mstrt_cycles = 0;
    exp_q.push_back({ERR_OK, 16'h0000});
    send(OP_START, 16'h0, 16'h0);
    exp_mstrt = 1;
    repeat (249) tick();
    tick();
    exp_mstrt = 0; exp_rsp_valid = 1;
    take_rsp(0);
    cmp("start_len", 16'(mstrt_cycles), 16'd250);

    // READ while running and an undefined opcode are both illegal.
    exp_q.push_back({ERR_ILLEGAL, 16'h0000});
    send(OP_READ, 16'h0010, 16'h0);
    exp_rsp_valid = 1;
    take_rsp(1);
    cmp("illegal_read_err", {14'b0, last_err}, 16'd2);
    exp_q.push_back({ERR_ILLEGAL, 16'h0000});
    send(3'd7, 16'h0, 16'h0);
    exp_rsp_valid = 1;
    take_rsp(0);

    // STOP: MT12 after 40 cycles.
    exp_q.push_back({ERR_OK, 16'h0000});
    send(OP_STOP, 16'h0, 16'h0);
    exp_mstp = 1;
    repeat (40) tick();
    pulse(4'b1000);
    exp_stopped = 1; exp_rsp_valid = 1;
    take_rsp(0);
    cmp("stop_mstp", MSTP, 16'h1);

    // LOAD 0x0C00 <- 0x1234.
    exp_q.push_back({ERR_OK, 16'h0000});
    send(OP_LOAD, 16'h0C00, 16'h1234);
    exp_mload = 1; exp_mdt = 16'h0C00;
    repeat (3) tick();
    pulse(4'b0001);
    repeat (3) tick();
    pulse(4'b0010);
    exp_mdt = 16'h1234;
    repeat (3) tick();
    pulse(4'b1000);
    exp_mload = 0; exp_mdt = 16'h0;
    tick();
    exp_rsp_valid = 1;
    take_rsp(0);

    // READ 0x0010 with MWL=0x5A5A, response held over 5 not-ready cycles.
    exp_q.push_back({ERR_OK, 16'h5A5A});
    send(OP_READ, 16'h0010, 16'hFFFF);
    exp_mread = 1; exp_mdt = 16'h0010;
    MWL = 16'h5A5A;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    MWL = 16'h0000;
    pulse(4'b1000);
    exp_mread = 0; exp_mdt = 16'h0;
    tick();
    exp_rsp_valid = 1;
    take_rsp(5);
    cmp("read_data", last_data, 16'h5A5A);
    cmp("read_err", {14'b0, last_err}, 16'd0);

    // RDCH with MT10 and MT12 together: capture still wins.
    exp_q.push_back({ERR_OK, 16'hA5C3});
    send(OP_RDCH, 16'h0123, 16'h0);
    exp_mrdch = 1; exp_mdt = 16'h0123;
    MWL = 16'hA5C3;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b1100);
    exp_mrdch = 0; exp_mdt = 16'h0;
    tick();
    exp_rsp_valid = 1;
    take_rsp(0);
    cmp("rdch_data", last_data, 16'hA5C3);

    // GOJAM during LDCH.
    exp_q.push_back({ERR_GOJAM, 16'h0000});
    send(OP_LDCH, 16'h0042, 16'h00FF);
    exp_mldch = 1; exp_mdt = 16'h0042;
    pulse(4'b0001);
    MGOJAM = 1;
    tick();
    MGOJAM = 0;
    exp_mldch = 0; exp_mdt = 16'h0; exp_stopped = 0;
    tick();
    exp_rsp_valid = 1;
    take_rsp(0);
    cmp("gojam_err", {14'b0, last_err}, 16'd3);
    cmp("gojam_mstp", MSTP, 16'h1);

    // Re-stop with an immediate MT12.
    exp_q.push_back({ERR_OK, 16'h0000});
    send(OP_STOP, 16'h0, 16'h0);
    pulse(4'b1000);
    exp_stopped = 1; exp_rsp_valid = 1;
    take_rsp(0);

    // READ with no MT01: watchdog expires after 100 waiting cycles.
    exp_q.push_back({ERR_TIMEOUT, 16'h0000});
    send(OP_READ, 16'h0020, 16'h0);
    exp_mread = 1; exp_mdt = 16'h0020;
    repeat (99) tick();
    tick();
    exp_mread = 0; exp_mdt = 16'h0;
    tick();
    exp_rsp_valid = 1;
    take_rsp(0);
    cmp("timeout_err", {14'b0, last_err}, 16'd1);

    // READ timing out after its MT10 capture keeps the captured data.
    exp_q.push_back({ERR_TIMEOUT, 16'hC3C3});
    send(OP_READ, 16'h0030, 16'h0);
    exp_mread = 1; exp_mdt = 16'h0030;
    MWL = 16'hC3C3;
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0100);
    MWL = 16'h0;
    repeat (97) tick();
    tick();
    exp_mread = 0; exp_mdt = 16'h0;
    tick();
    exp_rsp_valid = 1;
    take_rsp(0);
    cmp("timeout_capture", last_data, 16'hC3C3);

    // Reset in the middle of a LOAD data phase.
    send(OP_LOAD, 16'h0C00, 16'h1234);
    exp_mload = 1; exp_mdt = 16'h0C00;
    pulse(4'b0001);
    pulse(4'b0010);
    exp_mdt = 16'h1234;
    tick();
    SIM_RST_n = 1'b0;
    exp_reset();
    #1;
    cmp("rst_mid_mload", MLOAD, 16'h0);
    cmp("rst_mid_mdt", MDT, 16'h0);
    cmp("rst_mid_mstp", MSTP, 16'h0);
    cmp("rst_mid_stopped", stopped, 16'h0);
    cmp("rst_mid_cmd_ready", cmd_ready, 16'h1);
    tick();
    SIM_RST_n = 1'b1;
    repeat (2) tick();
    cmp("queue_empty", 16'(exp_q.size()), 16'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mon_sequencer.md
# mon_sequencer

Host-side controller for the AGC monitor (MON) port. It accepts one command at a time on a valid/ready interface and sequences MSTRT, MSTP, MREAD, MLOAD, MRDCH, MLDCH and the MDT bus against the core's MT01–MT12 timing pulses, then returns a response. It sits between a bench or FPGA host and the `agc`/`fpga_agc` top. It replaces hand-written `#delay` stimulus with cycle-exact monitor transactions.

## Interface
- `START_CYCLES`, default 250: SIM_CLK cycles that MSTRT is held high.
- `TIMEOUT_CYCLES`, default 65536: watchdog limit for waiting on any MT edge.
- `SIM_CLK  in  1`: sole clock; all logic on rising edge.
- `SIM_RST_n  in  1`: asynchronous active-low reset.
- `cmd_valid  in  1`, `cmd_ready  out  1`: command handshake.
- `cmd_op  in  3`: 0 START, 1 STOP, 2 LOAD, 3 READ, 4 LDCH, 5 RDCH; 6–7 illegal.
- `cmd_addr  in  16`, `cmd_data  in  16`: monitor address (channel address in bits 8:0 for LDCH/RDCH) and write data.
- `rsp_valid  out  1`, `rsp_ready  in  1`: response handshake.
- `rsp_data  out  16`, `rsp_err  out  2`: read data; 0 OK, 1 TIMEOUT, 2 ILLEGAL, 3 GOJAM.
- `MT01`, `MT07`, `MT10`, `MT12`, `MGOJAM  in  1 each`: core timing pulses and the GOJAM indicator, all synchronous to SIM_CLK.
- `MWL  in  16`: core write-line bus, used for read data.
- `MSTRT`, `MSTP`, `MREAD`, `MLOAD`, `MRDCH`, `MLDCH  out  1 each`: monitor controls.
- `MDT  out  16`: monitor data bus; bit 0 maps to MDT01.
- `stopped  out  1`: MSTP is asserted and the STOP command has completed.

## Operation
- States: IDLE, START, STOP_WAIT, ARM, ADDR, DATA, FINISH, RESP.
- IDLE: `cmd_ready`=1. A handshake registers the operands and leaves IDLE.
- ILLEGAL: an op of 6–7, or LOAD/READ/LDCH/RDCH while `stopped`=0, goes straight to RESP with err 2. No monitor signal toggles.
- START: clear MSTP and `stopped`, drive MSTRT=1 for exactly START_CYCLES cycles, then RESP with err 0.
- STOP: set MSTP=1 and go to STOP_WAIT. The first MT12 rising edge sets `stopped`=1 and goes to RESP. MSTP stays high until a later START.
- LOAD/LDCH: assert MLOAD (MLDCH) with MDT=addr, then go to ARM.
  - ARM waits for an MT01 edge, then ADDR.
  - ADDR waits for an MT07 edge, sets MDT=data, then DATA.
  - DATA waits for an MT12 edge, then FINISH.
- READ/RDCH: same path with MREAD (MRDCH), except MDT stays at addr. On the MT10 edge in DATA, `rsp_data`=MWL.
- FINISH: deassert the strobe and set MDT=0 for one cycle, then RESP.
- RESP: `rsp_valid`=1, holding `rsp_data`/`rsp_err` until `rsp_ready`, then IDLE.
- Watchdog: resets on entry to each wait state. Reaching TIMEOUT_CYCLES → FINISH with err 1. `rsp_data`=0 except for a READ timed out after its MT10 capture.
- MGOJAM=1 in any non-IDLE/RESP state → FINISH with err 3. After a GOJAM, `stopped` is cleared and MSTP is left unchanged.

## Timing
- Reset values: all monitor outputs 0, MDT 0, `stopped` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `cmd_ready` 1.
- MT edges are detected on registered inputs, giving a 1-cycle latency from input rise to action. A level held high counts as one edge.
- An MT12 edge in the same cycle as an MT10 edge: capture first, then advance.
- Command accepted to first strobe: 1 cycle.
- START: MSTRT high for START_CYCLES, `rsp_valid` on the following cycle.
- `cmd_ready` is low from acceptance until the RESP handshake completes. There is no overlap between commands.
- Reset mid-transaction drops all strobes immediately; any pending response is lost.

## Structure
- `mon_seq_pkg`: op encoding, err codes, state enum, MDT width constant.
- Sub-module `mon_edge_det`: registered rising-edge detector, instantiated for MT01, MT07, MT10 and MT12.
- The top contains the FSM, operand and data registers, START counter and watchdog.

## Test plan
- Reset then START → MSTRT high for exactly 250 cycles; response err 0; `stopped`=0.
- STOP, then MT12 pulse after 40 cycles → `stopped`=1 one cycle after the edge; MSTP stays 1.
- While stopped, LOAD addr 0x0C00 data 0x1234 → MDT=0x0C00 until the MT07 edge, then 0x1234; MLOAD drops one cycle after the MT12 edge.
- While stopped, READ addr 0x0010 with MWL=0x5A5A at the MT10 edge → `rsp_data` 0x5A5A, err 0; response held across 5 cycles of `rsp_ready`=0.
- READ while running → err 2 with no strobes. With TIMEOUT_CYCLES=100 and no MT01 → err 1 after 100 cycles.
- MGOJAM pulse during LDCH → strobes cleared, err 3, `stopped`=0. Reset asserted mid-LOAD → all outputs return to their reset values immediately.
